// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared word width, reset PC and instruction field positions for the fetch slice.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
package instruction_fetch_pkg;
    localparam int WORD_W = `WORD_WIDTH;
    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = '0;
    // Field positions consumed by decode; fetch never interprets them.
    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int RD_HI = 15;
    localparam int RD_LO = 11;
    localparam int FUNC_HI = 10;
    localparam int FUNC_LO = 0;
endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: instruction memory port plus IF/ID valid/ready handshake.
interface instruction_fetch_if import instruction_fetch_pkg::*; #(parameter int W = WORD_W);
    logic [W-1:0] imem_addr;
    logic [W-1:0] imem_instruction;
    logic         if_valid;
    logic         if_ready;
    logic [W-1:0] if_pc;
    logic [W-1:0] if_instruction;
    modport master(output imem_addr, if_valid, if_pc, if_instruction, input imem_instruction, if_ready);
    modport slave(input imem_addr, if_valid, if_pc, if_instruction, output imem_instruction, if_ready);
endinterface

// File: rtl/fetch_pc_counter.sv
// fetch_pc_counter: word-addressed program counter with redirect and increment enable.
module fetch_pc_counter import instruction_fetch_pkg::*; #(
    parameter int W = WORD_W,
    parameter logic [W-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         redirect_valid,
    input  logic [W-1:0] redirect_addr,
    input  logic         inc,
    output logic [W-1:0] pc
);
    always_ff @(posedge clk)
        if (!rst_n) pc <= RESET_PC;
        else if (redirect_valid) pc <= redirect_addr;
        else if (inc) pc <= pc + W'(1);
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner driving combinational imem, registering results into a valid/ready IF/ID stage.
module instruction_fetch import instruction_fetch_pkg::*; #(
    parameter int W = WORD_W,
    parameter logic [W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        fetch_en,
    input  logic                        redirect_valid,
    input  logic [W-1:0]                redirect_addr,
    output logic [W-1:0]                fetch_count,
    instruction_fetch_if.master         bus
);
    logic [W-1:0] pc;
    logic         fire;
    logic         load;
    assign fire = bus.if_valid & bus.if_ready;
    assign load = fetch_en & (!bus.if_valid | bus.if_ready);
    assign bus.imem_addr = pc;
    fetch_pc_counter #(.W(W), .RESET_PC(RESET_PC)) u_pc (
        .clk(clk),
        .rst_n(rst_n),
        .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr),
        .inc(load & !redirect_valid),
        .pc(pc)
    );
    // Redirect flushes the stage but still credits a coincident handoff.
    always_ff @(posedge clk)
        if (!rst_n) begin
            bus.if_valid <= 1'b0;
            bus.if_pc <= '0;
            bus.if_instruction <= '0;
            fetch_count <= '0;
        end else begin
            if (fire) fetch_count <= fetch_count + W'(1);
            if (redirect_valid) bus.if_valid <= 1'b0;
            else if (load) begin
                bus.if_valid <= 1'b1;
                bus.if_pc <= pc;
                bus.if_instruction <= bus.imem_instruction;
            end else if (fire) bus.if_valid <= 1'b0;
        end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed checks of fetch, backpressure, redirect, enable, wrap and reset.
module tb_instruction_fetch;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        fetch_en = 0;
    logic        redirect_valid = 0;
    logic [31:0] redirect_addr = 0;
    logic [31:0] fetch_count;
    int          total = 0;
    int          bad = 0;
    instruction_fetch_if #(.W(32)) bus ();
    instruction_fetch #(.W(32), .RESET_PC(32'd0)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fetch_en(fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr),
        .fetch_count(fetch_count),
        .bus(bus)
    );
    always #5 clk = ~clk;
    always_comb
        case (bus.imem_addr)
            32'd0: bus.imem_instruction = 32'h0022_0000;
            32'd1: bus.imem_instruction = 32'h0064_0000;
            32'd2: bus.imem_instruction = 32'h00A6_0000;
            32'd3: bus.imem_instruction = 32'h00E8_1000;
            default: bus.imem_instruction = 32'h0;
        endcase
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic state(input string tag, input logic v, input logic [31:0] p, input logic [31:0] ins,
                         input logic [31:0] a, input logic [31:0] cnt);
        chk({tag, ".valid"}, {31'd0, bus.if_valid}, {31'd0, v});
        chk({tag, ".pc"}, bus.if_pc, p);
        chk({tag, ".instr"}, bus.if_instruction, ins);
        chk({tag, ".addr"}, bus.imem_addr, a);
        chk({tag, ".count"}, fetch_count, cnt);
    endtask
    initial begin
        bus.if_ready = 0;
        step();
        step();
        state("reset", 0, 0, 0, 0, 0);
        rst_n = 1; fetch_en = 1; bus.if_ready = 1;
        step(); state("f0", 1, 0, 32'h0022_0000, 1, 0);
        step(); state("f1", 1, 1, 32'h0064_0000, 2, 1);
        bus.if_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step(); state("stall", 1, 1, 32'h0064_0000, 2, 1);
        end
        bus.if_ready = 1;
        step(); state("f2", 1, 2, 32'h00A6_0000, 3, 2);
        step(); state("f3", 1, 3, 32'h00E8_1000, 4, 3);
        step(); state("f4", 1, 4, 32'h0, 5, 4);
        redirect_valid = 1; redirect_addr = 32'd2;
        step(); chk("redir.valid", {31'd0, bus.if_valid}, 0);
        chk("redir.addr", bus.imem_addr, 2);
        chk("redir.count", fetch_count, 5);
        redirect_valid = 0;
        step(); state("tgt", 1, 2, 32'h00A6_0000, 3, 5);
        fetch_en = 0;
        step(); chk("en0.valid", {31'd0, bus.if_valid}, 0);
        chk("en0.addr", bus.imem_addr, 3);
        chk("en0.count", fetch_count, 6);
        step(); chk("en0b.valid", {31'd0, bus.if_valid}, 0);
        chk("en0b.addr", bus.imem_addr, 3);
        chk("en0b.count", fetch_count, 6);
        fetch_en = 1;
        step(); state("resume", 1, 3, 32'h00E8_1000, 4, 6);
        redirect_valid = 1; redirect_addr = 32'hFFFF_FFFF;
        step(); chk("wr.valid", {31'd0, bus.if_valid}, 0);
        chk("wr.addr", bus.imem_addr, 32'hFFFF_FFFF);
        redirect_valid = 0;
        step(); state("wr.top", 1, 32'hFFFF_FFFF, 0, 0, 7);
        step(); state("wr.zero", 1, 0, 32'h0022_0000, 1, 8);
        bus.if_ready = 0;
        step(); state("hold", 1, 0, 32'h0022_0000, 1, 8);
        rst_n = 0;
        #3 rst_n = 1;
        step(); state("glitch", 1, 0, 32'h0022_0000, 1, 8);
        rst_n = 0;
        step(); state("midrst", 0, 0, 0, 0, 0);
        rst_n = 1; bus.if_ready = 1;
        step(); state("restart", 1, 0, 32'h0022_0000, 1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage of the core. It owns the program counter, drives the word address into the combinational instruction memory, and registers the returned instruction into an IF/ID pipeline register. Downstream handshake is valid/ready. It supports redirect for branches and jumps, and a global fetch enable. The PC counts in word units (addr+1 per instruction), matching the instruction memory's addressing.

Parameters:
RESET_PC, 0, word address loaded into PC on reset
W, `WORD_WIDTH (32), width of PC, addresses and instructions

Ports:
clk  input  1  core clock, all state updates on rising edge
rst_n  input  1  synchronous, active-low reset
fetch_en  input  1  1 = fetching allowed; 0 = no new fetch, held output kept
redirect_valid  input  1  branch/jump taken this cycle
redirect_addr  input  W  new word address for PC
imem_addr  output  W  address to instruction memory, combinational = pc
imem_instruction  input  W  instruction memory data, valid same cycle as imem_addr
if_valid  output  1  IF/ID register holds a valid instruction
if_ready  input  1  decode accepts IF/ID contents this cycle
if_pc  output  W  word address of held instruction
if_instruction  output  W  held instruction
fetch_count  output  W  number of instructions accepted by decode (if_valid & if_ready), wraps

Behaviour:
- Reset (rst_n=0 at edge): pc=RESET_PC, if_valid=0, if_pc=0, if_instruction=0, fetch_count=0. Synchronous only; asserting mid-operation discards any held instruction.
- imem_addr = pc at all times, with no register. Latency: instruction at address A appears on if_instruction one cycle after pc=A is loaded into IF/ID.
- fire = if_valid & if_ready; load = fetch_en & (!if_valid | if_ready).
- Priority per cycle: reset > redirect > load > hold.
- Redirect: pc<=redirect_addr; if_valid<=0 (flush, even if fire); if_pc and if_instruction may hold stale data; no load that cycle. The first instruction from the new target is valid 2 cycles after redirect is sampled. fetch_count still increments if fire coincides with redirect.
- Load: if_instruction<=imem_instruction, if_pc<=pc, if_valid<=1, pc<=pc+1 (mod 2^W; 0xFFFFFFFF wraps to 0).
- No load and fire: if_valid<=0, pc unchanged.
- Neither: all state held. While if_valid=1 and if_ready=0, if_pc and if_instruction are stable.
- fetch_en=0: pc frozen; a held valid instruction remains until fired.
- Throughput: 1 instruction/cycle with if_ready=1 and fetch_en=1. No bubble on back-to-back fires.
- if_ready is ignored while if_valid=0. if_valid never depends combinationally on if_ready.
- Instruction content is not interpreted. An all-zero word is fetched as a normal instruction.

Decomposition:
- Shared package: W via settings.h `WORD_WIDTH; instruction field constants OPCODE[31:26], RS[25:21], RT[20:16], RD[15:11], FUNC[10:0] for decode; RESET_PC default.
- One natural sub-module: fetch_pc_counter (pc register with reset, redirect and increment-enable). The IF/ID register and handshake stay in the top.

Test Plan:
- Reset then fetch_en=1, if_ready=1, imem model {0:0x00220000, 1:0x00640000, 2:0x00A60000, 3:0x00E81000, else 0} -> if_valid rises cycle 1 with if_pc=0, if_instruction=0x00220000; then pc 1,2,3 on consecutive cycles, 0x00E81000 at if_pc=3; fetch_count=4 after 4 fires.
- if_ready=0 for 3 cycles while if_pc=1 -> if_pc/if_instruction hold 1/0x00640000, imem_addr stays 2, fetch_count constant; release -> if_pc=2 next cycle.
- redirect_valid=1, redirect_addr=5 while if_valid=1 and if_ready=1 -> next cycle if_valid=0 and imem_addr=5; following cycle if_valid=1, if_pc=5, if_instruction=0; fetch_count increments once.
- fetch_en=0 with if_ready=1 -> held instruction fires, if_valid=0 next cycle, pc frozen; fetch_en=1 resumes at the same pc.
- redirect_addr=0xFFFFFFFF then fetch -> if_pc=0xFFFFFFFF, next if_pc=0 (wrap).
- rst_n=0 for one cycle mid-stream with if_valid=1 and if_ready=0 -> next cycle if_valid=0, imem_addr=RESET_PC, fetch_count=0; an async pulse between edges has no effect.
